// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory array.
// Optional power-up clear sweep when MEM_ARB_INIT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_DEPTH  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  init_busy
);

    localparam int unsigned LAST_ADDR = MEM_DEPTH - 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef MEM_ARB_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
`else
    localparam state_t RST_STATE = ST_RUN;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic [ADDR_WIDTH-1:0] w_init_addr_nxt;
    logic                  r_last_grant;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_rd0;
    logic                  w_rd1;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic [DATA_WIDTH-1:0] r_rsp0_rdata;
    logic [DATA_WIDTH-1:0] r_rsp1_rdata;

    // State, sweep pointer and last-grant pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RST_STATE;
            r_init_addr  <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_init_addr <= w_init_addr_nxt;
            if (w_grant0) begin
                r_last_grant <= 1'b0;
            end else if (w_grant1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    // Next state, arbitration and memory port mux
    always_comb begin
        w_state_nxt     = r_state;
        w_init_addr_nxt = r_init_addr;
        w_grant0        = 1'b0;
        w_grant1        = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_addr      = req0_addr;
        w_mem_wdata     = '0;
        case (r_state)
            ST_INIT: begin
                w_mem_we        = 1'b1;
                w_mem_addr      = r_init_addr;
                w_init_addr_nxt = r_init_addr + ADDR_WIDTH'(1);
                if (r_init_addr == ADDR_WIDTH'(LAST_ADDR)) begin
                    w_state_nxt     = ST_RUN;
                    w_init_addr_nxt = '0;
                end
            end
            ST_RUN: begin
                // On a tie the port not granted last wins
                w_grant0 = req0_valid && (!req1_valid || r_last_grant);
                w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
                if (w_grant0) begin
                    w_mem_we    = req0_we;
                    w_mem_addr  = req0_addr;
                    w_mem_wdata = req0_wdata;
                end else if (w_grant1) begin
                    w_mem_we    = req1_we;
                    w_mem_addr  = req1_addr;
                    w_mem_wdata = req1_wdata;
                end
            end
            default: begin
                w_state_nxt = RST_STATE;
            end
        endcase
        if (rst) begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
            w_mem_we = 1'b0;
        end
    end

    assign w_rd0 = w_grant0 && !req0_we;
    assign w_rd1 = w_grant1 && !req1_we;

    // Array storage has no reset; contents survive rst
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Read responses; rdata holds until the next read on the same port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= w_rd0;
            r_rsp1_valid <= w_rd1;
            if (w_rd0) begin
                r_rsp0_rdata <= r_mem[w_mem_addr];
            end
            if (w_rd1) begin
                r_rsp1_rdata <= r_mem[w_mem_addr];
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Responses are forced quiet for the whole time rst is high
    assign rsp0_valid = r_rsp0_valid & ~rst;
    assign rsp1_valid = r_rsp1_valid & ~rst;
    assign rsp0_rdata = rst ? '0 : r_rsp0_rdata;
    assign rsp1_rdata = rst ? '0 : r_rsp1_rdata;

`ifdef MEM_ARB_INIT_EN
    assign init_busy = (r_state == ST_INIT) && !rst;
`else
    assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (DATA_WIDTH=64, ADDR_WIDTH=4).
// Adapts to builds with and without MEM_ARB_INIT_EN.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          init_busy;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    localparam logic [DW-1:0] D_BEEF = 64'h0000_0000_DEAD_BEEF;
    localparam logic [DW-1:0] D_55   = 64'h5555_0000_1234_5555;
    localparam logic [DW-1:0] D_66   = 64'h6666_AAAA_0000_6666;

    int            n_vec = 0;
    int            n_err = 0;
    int            step  = 0;
    logic [DW-1:0] model [16];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, step, act, exp);
        end
    endtask

    // Pops the expected read data whenever a response is presented
    always @(negedge clk) begin
        if (!rst && rsp0_valid) begin
            if (q0.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp0 unexpected (step %0d): data %h", step, rsp0_rdata);
            end else begin
                chk("rsp0_rdata", rsp0_rdata, q0.pop_front());
            end
        end
        if (!rst && rsp1_valid) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp1 unexpected (step %0d): data %h", step, rsp1_rdata);
            end else begin
                chk("rsp1_rdata", rsp1_rdata, q1.pop_front());
            end
        end
    end

    // One clock of stimulus; entered and left 1 time unit after a rising edge
    task automatic cyc(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [1:0] e_rdy, input logic [1:0] e_rv);
        step++;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        @(negedge clk);
        chk("ready", 64'({req1_ready, req0_ready}), 64'(e_rdy));
        chk("rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'(e_rv));
        if (req0_valid && req0_ready) begin
            if (req0_we) model[req0_addr] = req0_wdata;
            else         q0.push_back(model[req0_addr]);
        end
        if (req1_valid && req1_ready) begin
            if (req1_we) model[req1_addr] = req1_wdata;
            else         q1.push_back(model[req1_addr]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] e_rv);
        cyc(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0, 2'b00, e_rv);
    endtask

    // Releases rst and brings the block to RUN with address 7 known to be zero
    task automatic post_reset();
        rst = 1'b0;
`ifdef MEM_ARB_INIT_EN
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd7;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd7;
        for (int i = 0; i < 16; i++) begin
            step++;
            @(negedge clk);
            chk("init_busy sweep", 64'(init_busy), 64'd1);
            chk("ready in init", 64'({req1_ready, req0_ready}), 64'd0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
        idle(2'b00);
        step++;
        @(negedge clk);
        chk("init_busy done", 64'(init_busy), 64'd0);
        @(posedge clk);
        #1;
`else
        step++;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd7; req0_wdata = '0;
        @(negedge clk);
        chk("init_busy noinit", 64'(init_busy), 64'd0);
        chk("first-cycle accept", 64'({req1_ready, req0_ready}), 64'b01);
        model[7] = '0;
        @(posedge clk);
        #1;
`endif
        cyc(1'b1, 1'b0, 4'd7, '0, 1'b0, 1'b0, 4'd0, '0, 2'b01, 2'b00);
        idle(2'b01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        // Requests during reset must not be granted
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("reset ready", 64'({req1_ready, req0_ready}), 64'd0);
        chk("reset rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        chk("reset rsp0_rdata", rsp0_rdata, '0);
        chk("reset rsp1_rdata", rsp1_rdata, '0);
        chk("reset init_busy", 64'(init_busy), 64'd0);
        @(posedge clk);
        #1;
        post_reset();

        // Write on port 0, read back on port 1
        cyc(1'b1, 1'b1, 4'd3, D_BEEF, 1'b0, 1'b0, 4'd0, '0, 2'b01, 2'b00);
        cyc(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd3, '0, 2'b10, 2'b00);
        cyc(1'b1, 1'b1, 4'd5, D_55, 1'b0, 1'b0, 4'd0, '0, 2'b01, 2'b10);
        cyc(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b1, 4'd6, D_66, 2'b10, 2'b00);

        // Both ports reading: grants alternate starting with port 0
        cyc(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd6, '0, 2'b01, 2'b00);
        cyc(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd6, '0, 2'b10, 2'b01);
        cyc(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd6, '0, 2'b01, 2'b10);
        cyc(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd6, '0, 2'b10, 2'b01);
        cyc(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd6, '0, 2'b01, 2'b10);
        cyc(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd6, '0, 2'b10, 2'b01);
        idle(2'b10);

        // Lone requester on port 1: granted every cycle, back-to-back responses
        cyc(1'b0, 1'b1, 4'd9, D_66, 1'b1, 1'b0, 4'd3, '0, 2'b10, 2'b00);
        cyc(1'b0, 1'b1, 4'd9, D_66, 1'b1, 1'b0, 4'd5, '0, 2'b10, 2'b10);
        cyc(1'b0, 1'b1, 4'd9, D_66, 1'b1, 1'b0, 4'd6, '0, 2'b10, 2'b10);
        cyc(1'b0, 1'b1, 4'd9, D_66, 1'b1, 1'b0, 4'd3, '0, 2'b10, 2'b10);
        idle(2'b10);
        idle(2'b00);
        step++;
        @(negedge clk);
        chk("rsp1_rdata hold", rsp1_rdata, D_BEEF);
        chk("rsp0_rdata hold", rsp0_rdata, D_55);
        @(posedge clk);
        #1;

        // Reset in the cycle after a read is accepted drops the response
        cyc(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, 4'd0, '0, 2'b01, 2'b00);
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        q0.delete();
        q1.delete();
        step++;
        @(negedge clk);
        chk("midreset rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("midreset rsp0_rdata", rsp0_rdata, '0);
        chk("midreset init_busy", 64'(init_busy), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        post_reset();

        idle(2'b00);
        chk("q0 drained", 64'(q0.size()), 64'd0);
        chk("q1 drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of each memory word.
REQ-002 Parameter ADDR_WIDTH, default 10: width of each address.
REQ-003 Parameter MEM_DEPTH, default 2**ADDR_WIDTH: number of words in the internal array.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port reqN_valid (N = 0, 1), input, 1: requester N presents a request.
REQ-007 Port reqN_ready, output, 1: request N is accepted this cycle.
REQ-008 Port reqN_we, input, 1: 1 = write, 0 = read.
REQ-009 Port reqN_addr, input, ADDR_WIDTH: request address.
REQ-010 Port reqN_wdata, input, DATA_WIDTH: write data.
REQ-011 Port rspN_valid, output, 1: read data valid for requester N.
REQ-012 Port rspN_rdata, output, DATA_WIDTH: read data for requester N.
REQ-013 Port init_busy, output, 1: clear sweep in progress.

Function
- REQ-014 The block SHALL contain one MEM_DEPTH x DATA_WIDTH array with exactly one access (read or write) per cycle.
- REQ-015 The FSM SHALL have two states, INIT and RUN; INIT is entered only when MEM_ARB_INIT_EN is defined, and INIT moves to RUN after the final sweep address.
- REQ-016 In RUN, exactly one valid requester SHALL be granted per cycle: a lone valid requester wins; when both are valid, the requester not granted last wins (round-robin).
- REQ-017 reqN_ready SHALL be combinational, high only for the granted requester, and low for both in INIT.
- REQ-018 The last-grant pointer SHALL update only on an accepted request (valid && ready).
- REQ-019 An accepted write SHALL update the array at that clock edge; a read of the same address in any later cycle returns the new data.
- REQ-020 An accepted read SHALL assert rspN_valid for exactly one cycle, on the cycle after acceptance, with rspN_rdata equal to the array word at acceptance.
- REQ-021 rspN_rdata SHALL hold its value until the next read response on port N.
- REQ-022 Writes SHALL produce no response.
- REQ-023 Back-to-back reads on one port SHALL sustain one response per cycle.
- REQ-024 The requester that loses arbitration SHALL hold its request stable; the block stores nothing for it.
- REQ-025 A request with reqN_valid low SHALL never be granted, and SHALL not change the pointer.
- REQ-026 Address arithmetic SHALL use ADDR_WIDTH bits; addresses at or above MEM_DEPTH are not allowed when MEM_DEPTH < 2**ADDR_WIDTH.

Reset
- REQ-027 While rst is high, the block SHALL drive rsp0_valid = rsp1_valid = 0, rsp0_rdata = rsp1_rdata = 0, reqN_ready = 0, and set the last-grant pointer to 1, so port 0 wins the first tie.
- REQ-028 Asserting rst mid-operation SHALL drop any pending read response the next cycle, abort any sweep, and restart the sweep from address 0 after rst falls.
- REQ-029 init_busy SHALL be 0 during rst.
- REQ-030 Array contents SHALL be unaffected by rst itself.

Configuration
- REQ-031 Macro MEM_ARB_INIT_EN defined: on the first cycle after rst falls, the FSM SHALL enter INIT and write zero to addresses 0 .. MEM_DEPTH-1, one per cycle, with init_busy high for exactly MEM_DEPTH cycles, then enter RUN.
- REQ-032 Macro MEM_ARB_INIT_EN undefined: the block SHALL enter RUN directly and tie init_busy to 0; array contents are undefined until written, and requests are accepted from the first cycle after rst falls.

Verification (bench: DATA_WIDTH = 64, ADDR_WIDTH = 4)
- REQ-033 Init sweep, macro defined: release rst -> init_busy high for 16 cycles and both ready signals low; then a read of address 7 returns 0.
- REQ-034 Write/read: port 0 writes 0xDEAD_BEEF to address 3, next cycle port 1 reads address 3 -> rsp1_valid one cycle later with 0xDEAD_BEEF, and rsp0_valid stays 0.
- REQ-035 Tie alternation: both ports hold read requests for 6 cycles -> grants go 0, 1, 0, 1, 0, 1.
- REQ-036 Lone requester: only port 1 valid for 4 cycles -> port 1 granted every cycle, giving 4 responses on consecutive cycles.
- REQ-037 Reset mid-read: assert rst in the cycle after a read is accepted -> rsp0_valid stays 0 and rdata = 0; with the macro defined, the sweep restarts and init_busy is high for 16 cycles.
- REQ-038 No-init build, macro undefined: init_busy stays 0, and a request presented on the first post-reset cycle is accepted that cycle.
